// File: rtl/acc_fifo_port_if.sv
// Router/accelerator handshake bundle for one acc_fifo_port instance.
// The master side is the router/accelerator pair; the slave side is the FIFO port.
interface acc_fifo_port_if #(
   parameter int AW = 4
);
   logic          enable;
   logic          put_req;
   logic [31:0]   data_in;
   logic          get_req;
   logic [31:0]   data_out;
   logic          to_empty;
   logic          to_full;
   logic          from_empty;
   logic          from_full;
   logic          acc_rd_req;
   logic [31:0]   acc_rd_data;
   logic          acc_rd_valid;
   logic          acc_wr_req;
   logic [31:0]   acc_wr_data;
   logic [AW:0]   to_count;
   logic [AW:0]   from_count;
   logic          err_overflow;
   logic          err_underflow;

   modport master (
      output enable, put_req, data_in, get_req, acc_rd_req, acc_wr_req, acc_wr_data,
      input  data_out, to_empty, to_full, from_empty, from_full, acc_rd_data,
             acc_rd_valid, to_count, from_count, err_overflow, err_underflow
   );

   modport slave (
      input  enable, put_req, data_in, get_req, acc_rd_req, acc_wr_req, acc_wr_data,
      output data_out, to_empty, to_full, from_empty, from_full, acc_rd_data,
             acc_rd_valid, to_count, from_count, err_overflow, err_underflow
   );
endinterface

// File: rtl/acc_fifo_port.sv
// Accelerator-side responder: a to-acc FIFO (router push, accelerator pop) and a
// from-acc FIFO (accelerator push, router pop), with sticky protocol-error flags.
module acc_fifo_port #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   acc_fifo_port_if.slave   bus
);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

   logic [31:0]   to_mem_q   [DEPTH];
   logic [31:0]   from_mem_q [DEPTH];

   logic [AW-1:0] to_wptr_q, to_wptr_d, to_rptr_q, to_rptr_d;
   logic [AW-1:0] from_wptr_q, from_wptr_d, from_rptr_q, from_rptr_d;
   logic [AW:0]   to_count_q, to_count_d, from_count_q, from_count_d;
   logic [31:0]   data_out_q, data_out_d, acc_rd_data_q, acc_rd_data_d;
   logic          acc_rd_valid_q, acc_rd_valid_d;
   logic          err_overflow_q, err_overflow_d, err_underflow_q, err_underflow_d;

   logic run_s;
   logic to_empty_s, to_full_s, from_empty_s, from_full_s;
   logic to_push_s, to_pop_s, from_push_s, from_pop_s;

   // Flags come from the registered count, so same-cycle requests never affect them.
   assign to_empty_s   = (to_count_q == CNT_ZERO);
   assign to_full_s    = (to_count_q == CNT_FULL);
   assign from_empty_s = (from_count_q == CNT_ZERO);
   assign from_full_s  = (from_count_q == CNT_FULL);

   assign run_s       = bus.enable & ~reset;
   assign to_push_s   = run_s & bus.put_req    & ~to_full_s;
   assign to_pop_s    = run_s & bus.acc_rd_req & ~to_empty_s;
   assign from_push_s = run_s & bus.acc_wr_req & ~from_full_s;
   assign from_pop_s  = run_s & bus.get_req    & ~from_empty_s;

   // Next-state for pointers, counts, read registers and error flags.
   always_comb begin
      to_wptr_d       = to_wptr_q;
      to_rptr_d       = to_rptr_q;
      from_wptr_d     = from_wptr_q;
      from_rptr_d     = from_rptr_q;
      to_count_d      = to_count_q;
      from_count_d    = from_count_q;
      data_out_d      = data_out_q;
      acc_rd_data_d   = acc_rd_data_q;
      acc_rd_valid_d  = 1'b0;
      err_overflow_d  = err_overflow_q;
      err_underflow_d = err_underflow_q;
      if (!run_s) begin
         to_wptr_d       = PTR_ZERO;
         to_rptr_d       = PTR_ZERO;
         from_wptr_d     = PTR_ZERO;
         from_rptr_d     = PTR_ZERO;
         to_count_d      = CNT_ZERO;
         from_count_d    = CNT_ZERO;
         data_out_d      = 32'h0000_0000;
         acc_rd_data_d   = 32'h0000_0000;
         err_overflow_d  = 1'b0;
         err_underflow_d = 1'b0;
      end else begin
         if (to_push_s)   to_wptr_d   = to_wptr_q + PTR_ONE;   else to_wptr_d   = to_wptr_q;
         if (from_push_s) from_wptr_d = from_wptr_q + PTR_ONE; else from_wptr_d = from_wptr_q;
         if (to_pop_s) begin
            to_rptr_d      = to_rptr_q + PTR_ONE;
            acc_rd_data_d  = to_mem_q[to_rptr_q];
            acc_rd_valid_d = 1'b1;
         end else begin
            to_rptr_d      = to_rptr_q;
         end
         if (from_pop_s) begin
            from_rptr_d = from_rptr_q + PTR_ONE;
            data_out_d  = from_mem_q[from_rptr_q];
         end else begin
            from_rptr_d = from_rptr_q;
         end
         case ({to_push_s, to_pop_s})
            2'b10:   to_count_d = to_count_q + CNT_ONE;
            2'b01:   to_count_d = to_count_q - CNT_ONE;
            default: to_count_d = to_count_q;
         endcase
         case ({from_push_s, from_pop_s})
            2'b10:   from_count_d = from_count_q + CNT_ONE;
            2'b01:   from_count_d = from_count_q - CNT_ONE;
            default: from_count_d = from_count_q;
         endcase
         err_overflow_d  = err_overflow_q | (bus.put_req & to_full_s)
                                          | (bus.acc_wr_req & from_full_s);
         err_underflow_d = err_underflow_q | (bus.get_req & from_empty_s)
                                           | (bus.acc_rd_req & to_empty_s);
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_wptr_q       <= PTR_ZERO;
         to_rptr_q       <= PTR_ZERO;
         from_wptr_q     <= PTR_ZERO;
         from_rptr_q     <= PTR_ZERO;
         to_count_q      <= CNT_ZERO;
         from_count_q    <= CNT_ZERO;
         data_out_q      <= 32'h0000_0000;
         acc_rd_data_q   <= 32'h0000_0000;
         acc_rd_valid_q  <= 1'b0;
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         to_wptr_q       <= to_wptr_d;
         to_rptr_q       <= to_rptr_d;
         from_wptr_q     <= from_wptr_d;
         from_rptr_q     <= from_rptr_d;
         to_count_q      <= to_count_d;
         from_count_q    <= from_count_d;
         data_out_q      <= data_out_d;
         acc_rd_data_q   <= acc_rd_data_d;
         acc_rd_valid_q  <= acc_rd_valid_d;
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   // Storage arrays are intentionally left uncleared by reset and flush.
   always_ff @(posedge clk) begin
      if (to_push_s)   to_mem_q[to_wptr_q]     <= bus.data_in;
      if (from_push_s) from_mem_q[from_wptr_q] <= bus.acc_wr_data;
   end

   assign bus.data_out      = data_out_q;
   assign bus.acc_rd_data   = acc_rd_data_q;
   assign bus.acc_rd_valid  = acc_rd_valid_q;
   assign bus.to_empty      = to_empty_s;
   assign bus.to_full       = to_full_s;
   assign bus.from_empty    = from_empty_s;
   assign bus.from_full     = from_full_s;
   assign bus.to_count      = to_count_q;
   assign bus.from_count    = from_count_q;
   assign bus.err_overflow  = err_overflow_q;
   assign bus.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_acc_fifo_port.sv
// Directed self-checking bench for acc_fifo_port with DEPTH=16.
module tb_acc_fifo_port;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   acc_fifo_port_if #(.AW(4)) bus ();

   acc_fifo_port #(.DEPTH(16), .AW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.put_req    = 1'b0;
      bus.get_req    = 1'b0;
      bus.acc_rd_req = 1'b0;
      bus.acc_wr_req = 1'b0;
   endtask

   task automatic pulse_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_to_empty"},   32'(bus.to_empty),      32'd1);
      check_eq({tag, "_from_empty"}, 32'(bus.from_empty),    32'd1);
      check_eq({tag, "_to_full"},    32'(bus.to_full),       32'd0);
      check_eq({tag, "_from_full"},  32'(bus.from_full),     32'd0);
      check_eq({tag, "_to_count"},   32'(bus.to_count),      32'd0);
      check_eq({tag, "_from_count"}, 32'(bus.from_count),    32'd0);
      check_eq({tag, "_data_out"},   bus.data_out,           32'h0);
      check_eq({tag, "_acc_rd_data"},bus.acc_rd_data,        32'h0);
      check_eq({tag, "_rd_valid"},   32'(bus.acc_rd_valid),  32'd0);
      check_eq({tag, "_err_ovf"},    32'(bus.err_overflow),  32'd0);
      check_eq({tag, "_err_unf"},    32'(bus.err_underflow), 32'd0);
   endtask

   initial begin
      bus.enable      = 1'b1;
      bus.data_in     = 32'h0;
      bus.acc_wr_data = 32'h0;
      idle();

      // Reset with all strobes active: nothing may leak through.
      reset = 1'b1;
      bus.put_req = 1'b1; bus.get_req = 1'b1; bus.acc_rd_req = 1'b1; bus.acc_wr_req = 1'b1;
      bus.data_in = 32'h1234_5678; bus.acc_wr_data = 32'h8765_4321;
      tick();
      tick();
      check_cleared("reset");
      idle();
      reset = 1'b0;
      tick();

      // Fill to-acc with 0x100..0x10F.
      for (int i = 0; i < 16; i++) begin
         bus.put_req = 1'b1;
         bus.data_in = 32'h100 + 32'(i);
         tick();
         if (i == 0) check_eq("fill_first_not_empty", 32'(bus.to_empty), 32'd0);
      end
      check_eq("fill_to_full",  32'(bus.to_full),  32'd1);
      check_eq("fill_to_count", 32'(bus.to_count), 32'd16);
      bus.data_in = 32'h0000_DEAD;
      tick();
      check_eq("ovf_err",   32'(bus.err_overflow), 32'd1);
      check_eq("ovf_count", 32'(bus.to_count),     32'd16);
      idle();

      // Drain to-acc; the dropped 0xDEAD must never appear.
      for (int i = 0; i < 16; i++) begin
         bus.acc_rd_req = 1'b1;
         tick();
         check_eq("drain_valid", 32'(bus.acc_rd_valid), 32'd1);
         check_eq("drain_data",  bus.acc_rd_data,       32'h100 + 32'(i));
      end
      idle();
      tick();
      check_eq("drain_valid_drop", 32'(bus.acc_rd_valid), 32'd0);
      check_eq("drain_to_empty",   32'(bus.to_empty),     32'd1);
      check_eq("drain_hold",       bus.acc_rd_data,       32'h10F);
      check_eq("drain_no_unf",     32'(bus.err_underflow),32'd0);
      pulse_reset();

      // Wrap-around on from-acc: 10 in/out, then 12 in/out across the wrap.
      for (int i = 0; i < 10; i++) begin
         bus.acc_wr_req = 1'b1; bus.acc_wr_data = 32'h200 + 32'(i);
         tick();
      end
      idle();
      check_eq("wrap_count10", 32'(bus.from_count), 32'd10);
      for (int i = 0; i < 10; i++) begin
         bus.get_req = 1'b1;
         tick();
         check_eq("wrap_data_a", bus.data_out, 32'h200 + 32'(i));
      end
      idle();
      for (int i = 0; i < 12; i++) begin
         bus.acc_wr_req = 1'b1; bus.acc_wr_data = 32'h300 + 32'(i);
         tick();
      end
      idle();
      check_eq("wrap_count12", 32'(bus.from_count), 32'd12);
      for (int i = 0; i < 12; i++) begin
         bus.get_req = 1'b1;
         tick();
         check_eq("wrap_data_b", bus.data_out, 32'h300 + 32'(i));
      end
      idle();
      tick();
      check_eq("hold_data_out", bus.data_out,         32'h30B);
      check_eq("wrap_empty",    32'(bus.from_empty),  32'd1);

      // Underflow on router pop.
      bus.get_req = 1'b1;
      tick();
      idle();
      check_eq("unf_data_out", bus.data_out,            32'h30B);
      check_eq("unf_err",      32'(bus.err_underflow),  32'd1);
      check_eq("unf_count",    32'(bus.from_count),     32'd0);
      pulse_reset();

      // Full from-acc with simultaneous push and pop: push loses.
      for (int i = 0; i < 16; i++) begin
         bus.acc_wr_req = 1'b1; bus.acc_wr_data = 32'h400 + 32'(i);
         tick();
      end
      check_eq("full_from_full", 32'(bus.from_full), 32'd1);
      bus.acc_wr_data = 32'h0000_AAAA;
      bus.get_req = 1'b1;
      tick();
      idle();
      check_eq("fullpp_count", 32'(bus.from_count),   32'd15);
      check_eq("fullpp_err",   32'(bus.err_overflow), 32'd1);
      check_eq("fullpp_data",  bus.data_out,          32'h400);
      for (int i = 1; i < 16; i++) begin
         bus.get_req = 1'b1;
         tick();
         check_eq("fullpp_drain", bus.data_out, 32'h400 + 32'(i));
      end
      idle();
      check_eq("fullpp_empty", 32'(bus.from_empty), 32'd1);
      pulse_reset();

      // Empty to-acc with simultaneous put and accelerator pop: pop loses.
      bus.put_req = 1'b1; bus.data_in = 32'h55; bus.acc_rd_req = 1'b1;
      tick();
      idle();
      check_eq("emptypp_count", 32'(bus.to_count),      32'd1);
      check_eq("emptypp_err",   32'(bus.err_underflow), 32'd1);
      check_eq("emptypp_valid", 32'(bus.acc_rd_valid),  32'd0);
      bus.acc_rd_req = 1'b1;
      tick();
      idle();
      check_eq("emptypp_data",  bus.acc_rd_data,        32'h55);
      check_eq("emptypp_valid2",32'(bus.acc_rd_valid),  32'd1);

      // Queue 5 words in each FIFO, then drop enable with pops pending.
      for (int i = 0; i < 5; i++) begin
         bus.put_req = 1'b1;    bus.data_in     = 32'h500 + 32'(i);
         bus.acc_wr_req = 1'b1; bus.acc_wr_data = 32'h600 + 32'(i);
         tick();
      end
      idle();
      bus.get_req = 1'b1;
      tick();
      check_eq("pre_flush_to_count", 32'(bus.to_count), 32'd5);
      check_eq("pre_flush_data_out", bus.data_out,      32'h600);
      bus.get_req = 1'b0;
      bus.enable = 1'b0;
      bus.acc_rd_req = 1'b1; bus.get_req = 1'b1;
      bus.put_req = 1'b1;    bus.acc_wr_req = 1'b1;
      tick();
      check_cleared("flush");
      bus.enable = 1'b1;
      idle();
      tick();
      check_eq("post_flush_valid", 32'(bus.acc_rd_valid), 32'd0);
      check_eq("post_flush_empty", 32'(bus.to_empty),     32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
